// File: rtl/keypad_pkg.sv
// Shared state type, special key codes and the physical key map for the
// 4x4 matrix keypad entry path.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } kp_state_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Layout: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, columns 0..3.
  function automatic logic [3:0] kp_map(input logic [1:0] row_idx,
                                        input logic [1:0] col_idx);
    logic [3:0] code;
    code = 4'h0;
    case ({row_idx, col_idx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner with row synchronizer, press/release debounce and a
// single-cycle key_valid pulse per physical press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  // The cycle that enters a debounce state already counts as the first stable one.
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 2);

  kp_state_t        state_q;
  logic [3:0]       row_meta_q;
  logic [3:0]       row_s_q;
  logic [1:0]       col_idx_q;
  logic [1:0]       col_idx_d;
  logic [3:0]       col_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       row_idx_q;
  logic [1:0]       low_row_idx;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             all_high;

  assign col_idx_d = col_idx_q + 2'd1;
  assign all_high  = &row_s_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      row_s_q    <= 4'hF;
    end else begin
      row_meta_q <= row;
      row_s_q    <= row_meta_q;
    end
  end

  always_comb begin
    low_row_idx = 2'd0;
    casez (row_s_q)
      4'b???0: low_row_idx = 2'd0;
      4'b??01: low_row_idx = 2'd1;
      4'b?011: low_row_idx = 2'd2;
      4'b0111: low_row_idx = 2'd3;
      default: low_row_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      cnt_q       <= '0;
      row_idx_q   <= 2'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      unique case (state_q)
        SCAN: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_q <= '0;
            if (!all_high) begin
              row_idx_q <= low_row_idx;
              state_q   <= PRESS_DB;
            end else begin
              col_idx_q <= col_idx_d;
              col_q     <= ~(4'b0001 << col_idx_d);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PRESS_DB: begin
          if (row_s_q[row_idx_q]) begin
            cnt_q   <= '0;
            state_q <= SCAN;
          end else if (cnt_q == DB_LAST) begin
            cnt_q       <= '0;
            key_code_q  <= kp_map(row_idx_q, col_idx_q);
            key_valid_q <= 1'b1;
            state_q     <= HELD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (all_high) begin
            cnt_q   <= '0;
            state_q <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (!all_high) begin
            state_q <= HELD;
          end else if (cnt_q == DB_LAST) begin
            cnt_q     <= '0;
            col_idx_q <= col_idx_d;
            col_q     <= ~(4'b0001 << col_idx_d);
            state_q   <= SCAN;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end plus a two-digit BCD entry register and its binary value,
// feeding the display controller and downstream logic.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] bin_value
);

  logic [3:0] tens_q;
  logic [3:0] ones_q;
  logic [6:0] bin_q;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_scanner (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  // Digits shift in from the right; * clears; letters and # leave the entry alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      bin_q  <= 7'd0;
    end else begin
      if (key_valid) begin
        if (key_code <= 4'd9) begin
          tens_q <= ones_q;
          ones_q <= key_code;
        end else if (key_code == KEY_STAR) begin
          tens_q <= 4'd0;
          ones_q <= 4'd0;
        end
      end
      bin_q <= ({3'b000, tens_q} << 3) + ({3'b000, tens_q} << 1) + {3'b000, ones_q};
    end
  end

  assign tens      = tens_q;
  assign ones      = ones_q;
  assign bin_value = bin_q;

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Scans a 4x4 active-low matrix keypad, debounces presses and emits one key code per physical press. Digit keys shift into a two-digit BCD entry register; its binary value is also provided. This is the input-side counterpart of the switch-to-BCD display path: its `tens`/`ones` outputs feed the existing display controller, and `bin_value` feeds downstream logic.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each column is driven before rows are sampled. Must be at least 4.
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable cycles required for both press and release. Must be at least 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `row`  in  4  keypad rows, active-low (pulled up externally), asynchronous to `clk`.
- `col`  out  4  column drive, active-low, exactly one bit low at all times.
- `key_code`  out  4  code of the last accepted key.
- `key_valid`  out  1  one-cycle pulse when a new key is accepted.
- `tens`  out  4  BCD tens digit of the entry, range 0–9.
- `ones`  out  4  BCD ones digit of the entry, range 0–9.
- `bin_value`  out  7  binary value tens*10+ones, range 0–99.

## Operation
- **Row synchronizer:** `row` passes through a 2-flop synchronizer. All decisions use the synchronized value `row_s`.
- **Key map:** each row is listed from column 0 to column 3. Digits encode to their own value; A–D encode to 0xA–0xD; * is 0xE; # is 0xF.
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: * 0 # D
- **FSM states:** SCAN, PRESS_DB, HELD, RELEASE_DB.
  - **SCAN:** drive column `c` low for `SCAN_DIV` cycles. On the last dwell cycle, sample `row_s`.
    - All rows high: advance `c` cyclically (3 wraps to 0).
    - Otherwise: latch the lowest-index low row as `r`, keep `c` driven, clear the counter, go to PRESS_DB.
  - **PRESS_DB:** row `r` low counts up. Row `r` high returns to SCAN, resets the dwell counter, and keeps the same `c`.
    - When the count reaches `DEBOUNCE_CYCLES`: `key_code` <= map(`r`,`c`), pulse `key_valid`, go to HELD.
  - **HELD:** keep `c` driven. When all `row_s` are high, clear the counter and go to RELEASE_DB.
  - **RELEASE_DB:** all rows high counts up. Any row low returns to HELD.
    - When the count reaches `DEBOUNCE_CYCLES`: go to SCAN with the next column.
- **Entry register:** updated on the edge that ends the `key_valid` cycle.
  - Digit 0–9: `tens` <= `ones`, `ones` <= digit.
  - 0xE (*): `tens` <= 0, `ones` <= 0.
  - Any other code: entry unchanged, `key_valid` still pulses.
- **bin_value:** registered as `tens`*10+`ones`. Compute it as (`tens`<<3)+(`tens`<<1)+`ones`, in 7 bits, with no overflow possible.
- **Rollover:** a second key pressed while one is held is ignored. It is detected only after a full release and a subsequent scan.

## Timing
- **Reset values:** state SCAN, `c`=0, `col`=4'b1110, counters 0, synchronizer flops all ones, `key_code`=0, `key_valid`=0, `tens`=0, `ones`=0, `bin_value`=0.
- **Reset mid-press:** an in-progress press is discarded with no pulse. A key still held after reset release is detected and reported once.
- **Input latency:** 2 cycles from `row` to `row_s`.
- **Press latency:** with the key already down, `key_valid` rises exactly `DEBOUNCE_CYCLES` cycles after the sampling cycle.
- **Output latency:** with `key_valid` high in cycle N, `tens`/`ones` show the new value in N+1 and `bin_value` in N+2.
- **Pulse rule:** `key_valid` is never high for two consecutive cycles. Exactly one pulse occurs per press/release pair.
- **Column settling:** `col` changes only on a dwell boundary or on the RELEASE_DB→SCAN transition. Rows are never sampled in the first 3 cycles after a column change.

## Structure
- **Shared package `keypad_pkg`:**
  - state enum `kp_state_t` {SCAN, PRESS_DB, HELD, RELEASE_DB};
  - key constants `KEY_STAR`=4'hE and `KEY_HASH`=4'hF;
  - function `kp_map(row_idx, col_idx)` returning the 4-bit code.
- **Sub-module `keypad_scanner`:** contains the synchronizer, the FSM, column drive, and the `key_code`/`key_valid` outputs.
- **Top `keypad_entry`:** contains the BCD entry register and the `bin_value` conversion.

## Test plan
All scenarios run with `SCAN_DIV`=4 and `DEBOUNCE_CYCLES`=8, using a bench keypad model that connects `row[r]` to `col[c]` for each pressed key.
- Reset, no keys -> `col` cycles 1110, 1101, 1011, 0111, 1110 every 4 cycles; `key_valid` never asserts; all outputs 0.
- Press 4, then 2, with full release between -> two pulses, `key_code` 4 then 2; `tens`=4, `ones`=2, `bin_value`=42 two cycles after the second pulse.
- Bounce: toggle row 1/col 0 every 3 cycles for 30 cycles, then hold -> exactly one pulse with `key_code`=4, 8 cycles after stable sampling.
- Press 9, 9, 7, then * -> `bin_value` 9, 99, 97, then 0. A press of A -> pulse with `key_code`=0xA, entry unchanged.
- Hold 5 and press 6 while 5 is held, release both -> a single pulse with code 5; pressing 6 alone afterwards reports 6.
- Assert `rst_n`=0 during PRESS_DB while 8 is held, then release reset -> no pulse during reset; one pulse with code 8 after reset; `tens`/`ones` are 0 before that pulse.
